ex_alu_multicycle: RTL
======================

Name: ex_alu_multicycle

Overview:
- EX-stage ALU that consumes the 4-bit ALU select produced by the EX ALU control decoder and executes the selected operation on the two EX operands.
- add, sub, and, or and slt complete combinationally in the same cycle.
- mul (select 4'b1111) runs as an iterative shift-add multiplier. It holds the pipeline with Stall_EX until the product is ready.
- Sits between the ID/EX pipeline register and the EX/MEM register. Feeds the hazard unit (stall) and the branch logic (zero flag).

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CNT_WIDTH, 5, iteration counter width. Must satisfy 2**CNT_WIDTH == DATA_WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- ALU_Control_EX  input  4  operation select from the ALU control decoder.
- Operand_A_EX  input  DATA_WIDTH  rs value.
- Operand_B_EX  input  DATA_WIDTH  rt value or sign-extended immediate.
- Flush_EX  input  1  synchronous abort of an in-flight multiply.
- ALU_Result_EX  output  DATA_WIDTH  result.
- Zero_EX  output  1  asserted when ALU_Result_EX == 0.
- Stall_EX  output  1  hold request to the hazard unit (freeze PC, IF/ID, ID/EX).

Behaviour:
- Select encoding:
  - 0010 add: A+B, wrap modulo 2^32, no overflow trap.
  - 0110 sub: A-B, wrap.
  - 0000 and.
  - 0001 or.
  - 0111 slt: signed compare, result 32'h1 or 32'h0.
  - 1111 mul: low 32 bits of A*B. The low half is identical for signed and unsigned operands.
  - 0011 and every other code: result 32'h0, Zero_EX=1.
- Single-cycle ops: outputs are combinational from the inputs. Stall_EX=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If ALU_Control_EX==1111 and Flush_EX==0: drive Stall_EX=1 combinationally in this cycle.
  - At the next edge: latch A into multiplicand, B into multiplier, clear product accumulator and counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, one iteration per cycle:
  - If multiplier[0], accumulator += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - Stall_EX=1 throughout.
  - When counter==DATA_WIDTH-1 completes, go to DONE.
- DONE:
  - ALU_Result_EX = accumulator, Zero_EX derived from it, Stall_EX=0. The pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally. This prevents a re-launch on the same instruction.
  - If a new mul arrives the cycle after DONE, it launches from IDLE normally.
- Multiply latency:
  - Issue cycle (IDLE, stall high) + 32 BUSY cycles + 1 DONE cycle = 34 cycles in EX.
  - Stall_EX is high for exactly 33 consecutive cycles.
- During IDLE and BUSY with select 1111, ALU_Result_EX reads 32'h0. The result is only meaningful in DONE.
- Operands are latched at launch. Changes on Operand_A/B_EX during BUSY have no effect.
- Flush_EX:
  - In BUSY: go to IDLE at the next edge and drop Stall_EX in that cycle's combinational output. No result is produced.
  - In IDLE: suppresses launch.
  - In DONE: no effect.
- Reset (Reset_n=0, any time, including mid-multiply):
  - State=IDLE, counter=0, accumulator/multiplicand/multiplier=0.
  - Stall_EX=0, ALU_Result_EX=0, Zero_EX=1 (given a non-mul select, or the state-driven zero result).
- Simultaneous events:
  - Reset dominates Flush.
  - Flush dominates launch and iteration.

Decomposition:
- Shared package, alu_pkg:
  - ALU select constants: ALU_ADD 4'b0010, ALU_SUB 4'b0110, ALU_AND 4'b0000, ALU_OR 4'b0001, ALU_SLT 4'b0111, ALU_MUL 4'b1111, ALU_X 4'b0011.
  - FSM state encoding: IDLE 2'b00, BUSY 2'b01, DONE 2'b10.
  - The decoder and this block both import it.
- One sub-module, ex_seq_multiplier:
  - Owns the FSM, counter and shift-add datapath.
  - Ports: Clk, Reset_n, Start, Flush, A, B, Busy, Done, Product.
- Top level: combinational op mux plus stall/result muxing.

Test Plan:
- Reset state: Reset_n=0 with select 1111 → Stall_EX=0, ALU_Result_EX=0, Zero_EX=1. Release reset → launch occurs on the first edge after release.
- Single-cycle ops:
  - A=5, B=7: add → 12, sub → 32'hFFFFFFFE (Zero_EX=0), and → 5, or → 7.
  - sub with A=B=9 → 0, Zero_EX=1.
  - slt A=32'hFFFFFFFF, B=1 → 1.
  - select 0011 → 0, Zero_EX=1.
- Multiply:
  - 7×6: Stall_EX high 33 cycles, then DONE cycle shows 42, then IDLE.
  - 32'hFFFFFFFF×3 → 32'hFFFFFFFD.
  - 32'h00010000×32'h00010000 → 0 with Zero_EX=1.
- Operand stability: change A/B mid-BUSY → product still reflects the latched values.
- Flush: Flush_EX pulsed at BUSY iteration 10 → Stall_EX low that cycle, state IDLE next cycle, no DONE. Back-to-back muls 3×4 then 5×5 → 12 then 25, each with a 33-cycle stall.
- Reset mid-multiply: Reset_n pulsed low at iteration 20 → immediate IDLE, Stall_EX=0. After release with select 1111 held, the multiply relaunches and a full 33-cycle stall follows.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU select codes and multiplier FSM state encoding used by
//            the EX ALU control decoder and the EX-stage ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU select codes produced by the ALU control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_X   = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  // Iterative multiplier sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : ex_seq_multiplier
// Brief    : Iterative shift-add multiplier producing the low DATA_WIDTH bits
//            of A*B. One multiplier bit is consumed per cycle; operands are
//            captured at launch. Flush aborts an in-flight product.
//            CNT_WIDTH must satisfy 2**CNT_WIDTH == DATA_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module ex_seq_multiplier
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Product
);

  // Counter value of the final iteration
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  mul_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  // State and datapath registers, cleared asynchronously on reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Next-state and shift-add iteration; Flush overrides launch and iteration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          state_d  = BUSY;
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      // Always return to IDLE so the same instruction cannot relaunch
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    Busy    = (state_q == BUSY);
    Done    = (state_q == DONE);
    Product = acc_q;
  end

endmodule
`default_nettype wire

// File: rtl/ex_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_multicycle
// Brief    : EX-stage ALU. add/sub/and/or/slt are single-cycle combinational;
//            mul runs on an iterative multiplier and holds the pipeline via
//            Stall_EX until the product is presented in the DONE cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [3:0]            ALU_Control_EX,
  input  logic [DATA_WIDTH-1:0] Operand_A_EX,
  input  logic [DATA_WIDTH-1:0] Operand_B_EX,
  input  logic                  Flush_EX,
  output logic [DATA_WIDTH-1:0] ALU_Result_EX,
  output logic                  Zero_EX,
  output logic                  Stall_EX
);

  logic                  is_mul;
  logic                  mul_busy;
  logic                  mul_done;
  logic                  mul_idle;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] op_result;

  assign is_mul = (ALU_Control_EX == ALU_MUL);

  ex_seq_multiplier #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_mul (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (is_mul),
    .Flush   (Flush_EX),
    .A       (Operand_A_EX),
    .B       (Operand_B_EX),
    .Busy    (mul_busy),
    .Done    (mul_done),
    .Product (mul_product)
  );

  // Single-cycle operation mux; undefined selects produce zero
  always_comb begin
    op_result = '0;
    case (ALU_Control_EX)
      ALU_ADD: op_result = Operand_A_EX + Operand_B_EX;
      ALU_SUB: op_result = Operand_A_EX - Operand_B_EX;
      ALU_AND: op_result = Operand_A_EX & Operand_B_EX;
      ALU_OR:  op_result = Operand_A_EX | Operand_B_EX;
      ALU_SLT: op_result = {{(DATA_WIDTH-1){1'b0}},
                            ($signed(Operand_A_EX) < $signed(Operand_B_EX))};
      default: op_result = '0;
    endcase
  end

  // Stall covers the issue cycle and every BUSY cycle; reset and flush drop it
  // immediately so the hazard unit never sees a stale hold request
  always_comb begin
    mul_idle = !mul_busy && !mul_done;
    Stall_EX = Reset_n && !Flush_EX && (mul_busy || (mul_idle && is_mul));
  end

  // Result select: a mul only shows its product in the DONE cycle
  always_comb begin
    ALU_Result_EX = op_result;
    if (is_mul) begin
      ALU_Result_EX = mul_done ? mul_product : '0;
    end
    Zero_EX = (ALU_Result_EX == '0);
  end

endmodule
`default_nettype wire
